// File: rtl/uart_bus_arbiter_if.sv
// Client and UART side signals of uart_bus_arbiter; the arbiter uses the slave modport.
interface uart_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_dir;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic                 rsp_valid;
  logic                 rsp_error;
  logic [7:0]           rsp_data;
  logic                 busy;
  logic                 uart_receive_transmit;
  logic [7:0]           uart_serial_data;
  logic                 uart_reset_n;
  logic                 uart_done;
  logic                 uart_error;
  logic [7:0]           uart_data_out;

  modport slave (
    input  req, req_dir, req_data, uart_done, uart_error, uart_data_out,
    output grant, rsp_valid, rsp_error, rsp_data, busy,
           uart_receive_transmit, uart_serial_data, uart_reset_n
  );

  modport master (
    output req, req_dir, req_data, uart_done, uart_error, uart_data_out,
    input  grant, rsp_valid, rsp_error, rsp_data, busy,
           uart_receive_transmit, uart_serial_data, uart_reset_n
  );
endinterface

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing one half-duplex UART among NUM_REQ requesters, with timeout/abort.
// Define UART_ARB_RETRY_EN to reissue failed transfers up to MAX_RETRIES times.
module uart_bus_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned ABORT_CYCLES   = 2,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input logic               uart_clk,
  input logic               reset,
  uart_bus_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned ABT_W = $clog2(ABORT_CYCLES) + 1;
  localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1) + 1;
`ifdef UART_ARB_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               dir_q, dir_d;
  logic [7:0]         data_q, data_d;
  logic               rt_q, rt_d;
  logic [7:0]         serial_q, serial_d;
  logic               uart_rst_n_q, uart_rst_n_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ABT_W-1:0]   abort_q, abort_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               rsp_error_q, rsp_error_d;
  logic [7:0]         rsp_data_q, rsp_data_d;

  logic               found;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W:0]     cand;
  logic               fail;
  logic               can_retry;

  // Rotating search starting at the pointer; cand is one bit wider so the wrap is a single subtract.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && bus.req[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[PTR_W-1:0];
      end
    end
  end

  assign can_retry = RETRY_EN && (retry_q < RTY_W'(MAX_RETRIES));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    dir_d        = dir_q;
    data_d       = data_q;
    rt_d         = rt_q;
    serial_d     = serial_q;
    uart_rst_n_d = uart_rst_n_q;
    timer_d      = timer_q;
    abort_d      = abort_q;
    retry_d      = retry_q;
    rsp_error_d  = rsp_error_q;
    rsp_data_d   = rsp_data_q;
    fail         = 1'b0;
    case (state_q)
      S_IDLE: begin
        retry_d = '0;
        if (found) begin
          owner_d      = sel;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          dir_d        = bus.req_dir[sel];
          data_d       = bus.req_data[{sel, 3'b000} +: 8];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rt_d     = dir_q;
        serial_d = data_q;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        // Error beats done; done beats the timeout on the final cycle.
        if (bus.uart_error) begin
          fail = 1'b1;
        end else if (bus.uart_done) begin
          rsp_data_d  = dir_q ? bus.uart_data_out : 8'h00;
          rsp_error_d = 1'b0;
          state_d     = S_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          fail = 1'b1;
        end
        if (fail) begin
          abort_d      = '0;
          uart_rst_n_d = 1'b0;
          rt_d         = 1'b1;
          state_d      = S_ABORT;
        end
      end
      S_ABORT: begin
        if (abort_q == ABT_W'(ABORT_CYCLES - 1)) begin
          uart_rst_n_d = 1'b1;
          if (can_retry) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            rsp_error_d = 1'b1;
            rsp_data_d  = 8'h00;
            state_d     = S_RESP;
          end
        end else begin
          abort_d = abort_q + 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        grant_d = '0;
        rt_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      dir_q        <= 1'b0;
      data_q       <= '0;
      rt_q         <= 1'b1;
      serial_q     <= '0;
      uart_rst_n_q <= 1'b1;
      timer_q      <= '0;
      abort_q      <= '0;
      retry_q      <= '0;
      rsp_error_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      dir_q        <= dir_d;
      data_q       <= data_d;
      rt_q         <= rt_d;
      serial_q     <= serial_d;
      uart_rst_n_q <= uart_rst_n_d;
      timer_q      <= timer_d;
      abort_q      <= abort_d;
      retry_q      <= retry_d;
      rsp_error_q  <= rsp_error_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.grant                 = grant_q;
  assign bus.rsp_valid             = (state_q == S_RESP);
  assign bus.rsp_error             = rsp_error_q;
  assign bus.rsp_data              = rsp_data_q;
  assign bus.busy                  = (state_q != S_IDLE);
  assign bus.uart_receive_transmit = rt_q;
  assign bus.uart_serial_data      = serial_q;
  assign bus.uart_reset_n          = uart_rst_n_q;
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Scoreboard bench for uart_bus_arbiter: directed transfers push expected responses,
// a negedge monitor pops and compares on every rsp_valid and checks abort pulses.
module tb_uart_bus_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned AB = 2;
  localparam int unsigned MR = 2;
`ifdef UART_ARB_RETRY_EN
  localparam int EXP_TRIES = 3;
`else
  localparam int EXP_TRIES = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_bus_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_bus_arbiter #(
    .NUM_REQ(NR),
    .TIMEOUT_CYCLES(TO),
    .ABORT_CYCLES(AB),
    .MAX_RETRIES(MR)
  ) dut (
    .uart_clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic       err;
    logic [7:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   falls = 0;
  int   low_len = 0;
  logic rn_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT did not respond within the cycle budget", name);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (bus.grant === 4'b0000 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) expire(name);
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while (bus.busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) expire(name);
  endtask

  task automatic pulse_done(input logic [7:0] d);
    bus.uart_data_out = d;
    bus.uart_done     = 1'b1;
    @(negedge clk);
    bus.uart_done     = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_grant"},     32'(bus.grant), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'h0);
    chk({tag, "_rsp_data"},  32'(bus.rsp_data), 32'h0);
    chk({tag, "_busy"},      32'(bus.busy), 32'h0);
    chk({tag, "_rt"},        32'(bus.uart_receive_transmit), 32'h1);
    chk({tag, "_serial"},    32'(bus.uart_serial_data), 32'h0);
    chk({tag, "_uart_rst"},  32'(bus.uart_reset_n), 32'h1);
  endtask

  // Monitor: scoreboard pop on rsp_valid, plus abort pulse length and direction.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rn_prev = 1'b1;
      low_len = 0;
    end else begin
      if (bus.rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          expire("unexpected_rsp");
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_grant", 32'(bus.grant), 32'(mon_e.grant));
          chk("rsp_error", 32'(bus.rsp_error), 32'(mon_e.err));
          chk("rsp_data",  32'(bus.rsp_data), 32'(mon_e.data));
        end
      end
      if (bus.uart_reset_n === 1'b0) begin
        if (rn_prev) falls++;
        low_len++;
        chk("abort_rt", 32'(bus.uart_receive_transmit), 32'h1);
      end else if (!rn_prev) begin
        chk("abort_len", 32'(low_len), 32'(AB));
        low_len = 0;
      end
      rn_prev = bus.uart_reset_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2b [4];
    logic [3:0] g;
    int f0;
    int n;
    t2b[0] = 8'h11; t2b[1] = 8'h22; t2b[2] = 8'h33; t2b[3] = 8'h44;
    bus.req = '0; bus.req_dir = '0; bus.req_data = '0;
    bus.uart_done = 1'b0; bus.uart_error = 1'b0; bus.uart_data_out = '0;

    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // T2: all requesting, rotation from pointer 0; transmit yields rsp_data 0 despite uart_data_out
    bus.req = 4'b1111; bus.req_dir = 4'b0000; bus.req_data = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      g = 4'(1 << (k % 4));
      exp_q.push_back({g, 1'b0, 8'h00});
      wait_grant("t2_grant_wait");
      chk("t2_grant", 32'(bus.grant), 32'(g));
      @(negedge clk);
      chk("t2_serial", 32'(bus.uart_serial_data), 32'(t2b[k % 4]));
      repeat (2) @(negedge clk);
      pulse_done(8'hEE);
      if (k == 4) bus.req = '0;
      wait_idle("t2_idle", 20);
    end

    // T1: grant one cycle after req; done 10 cycles after ISSUE
    exp_q.push_back({4'b0001, 1'b0, 8'h00});
    bus.req = 4'b0001; bus.req_dir = 4'b0000; bus.req_data = 32'h000000A5;
    @(negedge clk);
    chk("t1_grant", 32'(bus.grant), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    chk("t1_rt", 32'(bus.uart_receive_transmit), 32'h0);
    chk("t1_serial", 32'(bus.uart_serial_data), 32'hA5);
    repeat (9) @(negedge clk);
    pulse_done(8'h00);
    bus.req = '0;
    wait_idle("t1_idle", 20);

    // T3: receive; req dropped right after grant must not cancel the transfer
    exp_q.push_back({4'b0100, 1'b0, 8'h3C});
    bus.req = 4'b0100; bus.req_dir = 4'b0100; bus.req_data = 32'h00990000;
    wait_grant("t3_grant_wait");
    chk("t3_grant", 32'(bus.grant), 32'h4);
    bus.req = '0;
    @(negedge clk);
    chk("t3_rt", 32'(bus.uart_receive_transmit), 32'h1);
    repeat (3) @(negedge clk);
    pulse_done(8'h3C);
    wait_idle("t3_idle", 20);

    // T7: done on the final timeout cycle wins; pointer 3 wraps to requester 0
    f0 = falls;
    exp_q.push_back({4'b0001, 1'b0, 8'h81});
    bus.req = 4'b0001; bus.req_dir = 4'b0001;
    wait_grant("t7_grant_wait");
    chk("t7_grant", 32'(bus.grant), 32'h1);
    bus.req = '0;
    repeat (16) @(negedge clk);
    pulse_done(8'h81);
    wait_idle("t7_idle", 20);
    chk("t7_aborts", 32'(falls - f0), 32'h0);

    // T4: no done -> abort after TO WAIT cycles
    f0 = falls;
    exp_q.push_back({4'b1000, 1'b1, 8'h00});
    bus.req = 4'b1000; bus.req_dir = 4'b1000;
    wait_grant("t4_grant_wait");
    bus.req = '0;
    n = 0;
    while (bus.uart_reset_n === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_cycles", 32'(n), 32'd17);
    chk("t4_busy", 32'(bus.busy), 32'h1);
    wait_idle("t4_idle", 300);
    chk("t4_aborts", 32'(falls - f0), 32'(EXP_TRIES));

    // T5: error and done together on every try; error wins, data forced to 0
    f0 = falls;
    exp_q.push_back({4'b0010, 1'b1, 8'h00});
    bus.req = 4'b0010; bus.req_dir = 4'b0010; bus.uart_data_out = 8'h77;
    wait_grant("t5_grant_wait");
    bus.req = '0;
    bus.uart_error = 1'b1;
    bus.uart_done  = 1'b1;
    wait_idle("t5_idle", 300);
    bus.uart_error = 1'b0;
    bus.uart_done  = 1'b0;
    chk("t5_aborts", 32'(falls - f0), 32'(EXP_TRIES));

    // T6: reset mid-WAIT, then pointer must restart at 0
    bus.req = 4'b0001; bus.req_dir = 4'b0000; bus.req_data = 32'h0000005A;
    wait_grant("t6_grant_wait");
    bus.req = '0;
    repeat (4) @(negedge clk);
    chk("t6_serial_pre", 32'(bus.uart_serial_data), 32'h5A);
    rst_n = 1'b0;
    #1;
    check_reset("t6");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({4'b0010, 1'b0, 8'h00});
    bus.req = 4'b1010; bus.req_dir = 4'b0000;
    wait_grant("t6_grant_wait2");
    chk("t6_grant", 32'(bus.grant), 32'h2);
    repeat (3) @(negedge clk);
    pulse_done(8'h00);
    bus.req = '0;
    wait_idle("t6_idle", 20);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
